// File: rtl/imem_boot_loader_if.sv
// Signal bundle between the boot loader, its byte source and the instruction memory.
// The loader uses the master modport; the byte source and memory side use slave.
interface imem_boot_loader_if #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 32
);
  logic                    start;
  logic [ADDRESS_SIZE:0]   word_count;
  logic                    abort;
  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    byte_ready;
  logic                    ins_write;
  logic [ADDRESS_SIZE-1:0] wr_addr;
  logic [N-1:0]            instruction_in;
  logic                    cpu_hold;
  logic                    done;

  modport master (
    input  start, word_count, abort, byte_valid, byte_data,
    output byte_ready, ins_write, wr_addr, instruction_in, cpu_hold, done
  );

  modport slave (
    output start, word_count, abort, byte_valid, byte_data,
    input  byte_ready, ins_write, wr_addr, instruction_in, cpu_hold, done
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: packs a little-endian byte stream into N-bit
// words and writes them to consecutive addresses from 0, holding the core meanwhile.
module imem_boot_loader #(
  parameter int ADDRESS_SIZE = 10,
  parameter int N            = 32
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.master  bus
);
  localparam int BYTES  = N / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0]     LAST_IDX  = BIDX_W'(BYTES - 1);
  localparam logic [ADDRESS_SIZE:0] MAX_WORDS = {1'b1, {ADDRESS_SIZE{1'b0}}};
  localparam logic [ADDRESS_SIZE:0] ONE_WORD  = (ADDRESS_SIZE + 1)'(1);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [ADDRESS_SIZE:0]   words_q, words_d;
  logic [ADDRESS_SIZE:0]   target_q, target_d;
  logic [N-1:0]            asm_q, asm_d;
  logic [ADDRESS_SIZE:0]   target_new;

  // Any count with the top bit set is at least the full memory depth.
  assign target_new = bus.word_count[ADDRESS_SIZE] ? MAX_WORDS : bus.word_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      byte_idx_q <= '0;
      words_q    <= '0;
      target_q   <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      byte_idx_q <= byte_idx_d;
      words_q    <= words_d;
      target_q   <= target_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    byte_idx_d = byte_idx_q;
    words_d    = words_q;
    target_d   = target_q;
    asm_d      = asm_q;
    case (state_q)
      IDLE: begin
        if (!bus.abort && bus.start) begin
          target_d   = target_new;
          addr_d     = '0;
          byte_idx_d = '0;
          words_d    = '0;
          state_d    = (target_new == '0) ? FINISH : RECV;
        end
      end
      RECV: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.byte_valid) begin
          asm_d[8*byte_idx_q +: 8] = bus.byte_data;
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            state_d    = WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // The write itself is decoded from state, so an abort here cannot cancel it.
        addr_d  = addr_q + 1'b1;
        words_d = words_q + ONE_WORD;
        if (bus.abort)                         state_d = IDLE;
        else if (words_q + ONE_WORD == target_q) state_d = FINISH;
        else                                    state_d = RECV;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.byte_ready     = (state_q == RECV);
  assign bus.ins_write      = (state_q == WRITE);
  assign bus.cpu_hold       = (state_q != IDLE);
  assign bus.done           = (state_q == FINISH);
  assign bus.wr_addr        = addr_q;
  assign bus.instruction_in = asm_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed test of imem_boot_loader: packing, latency, stalls, zero-length loads,
// abort, address clamping/wrap and asynchronous reset.
module tb_imem_boot_loader;
  localparam int AS = 10;
  localparam int NW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDRESS_SIZE(AS), .N(NW)) bus ();
  imem_boot_loader #(.ADDRESS_SIZE(AS), .N(NW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int ready_bad  = 0;
  logic [AS-1:0] wa_q[$];
  logic [NW-1:0] wd_q[$];

  // Record every memory write and done pulse as seen away from the active edge.
  always @(negedge clk) begin
    if (bus.ins_write === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.instruction_in);
      if (bus.byte_ready !== 1'b0) ready_bad++;
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      compared++;
      mismatched++;
      $error("FAIL send_timeout observed=byte_ready_low expected=byte_ready_high");
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic start_load(input int wc);
    bus.start      = 1'b1;
    bus.word_count = (AS + 1)'(wc);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  logic [7:0] stream [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'hB3, 8'h05, 8'h00, 8'h00};

  initial begin
    int d0;
    int bad;
    bus.start = 1'b0; bus.word_count = '0; bus.abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cpu_hold",  64'(bus.cpu_hold),       64'd0);
    chk("rst_byte_rdy",  64'(bus.byte_ready),     64'd0);
    chk("rst_ins_write", 64'(bus.ins_write),      64'd0);
    chk("rst_done",      64'(bus.done),           64'd0);
    chk("rst_instr",     64'(bus.instruction_in), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Two words back-to-back with exact latency checks
    d0 = done_cnt;
    start_load(2);
    chk("t2_hold_after_start", 64'(bus.cpu_hold), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    chk("t2_w2_ins_write", 64'(bus.ins_write),      64'd1);
    chk("t2_w2_addr",      64'(bus.wr_addr),        64'd1);
    chk("t2_w2_data",      64'(bus.instruction_in), 64'h000005B3);
    @(negedge clk);
    chk("t2_done",         64'(bus.done),      64'd1);
    chk("t2_hold_at_done", 64'(bus.cpu_hold),  64'd1);
    chk("t2_no_write",     64'(bus.ins_write), 64'd0);
    @(negedge clk);
    chk("t2_done_drop",    64'(bus.done),     64'd0);
    chk("t2_hold_drop",    64'(bus.cpu_hold), 64'd0);
    chk("t2_nwrites",      64'(wa_q.size()),  64'd2);
    chk("t2_addr0",        64'(wa_q[0]),      64'd0);
    chk("t2_data0",        64'(wd_q[0]),      64'h00500013);
    chk("t2_data1",        64'(wd_q[1]),      64'h000005B3);
    chk("t2_done_cnt",     64'(done_cnt - d0), 64'd1);
    wa_q.delete(); wd_q.delete();

    // Same stream with random gaps between bytes
    start_load(2);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(stream[i]);
    end
    wait_done("t3_done_seen", 20);
    @(negedge clk);
    chk("t3_nwrites",   64'(wa_q.size()), 64'd2);
    chk("t3_addr0",     64'(wa_q[0]),     64'd0);
    chk("t3_addr1",     64'(wa_q[1]),     64'd1);
    chk("t3_data0",     64'(wd_q[0]),     64'h00500013);
    chk("t3_data1",     64'(wd_q[1]),     64'h000005B3);
    chk("t3_ready_bad", 64'(ready_bad),   64'd0);
    wa_q.delete(); wd_q.delete();

    // Zero-length load
    start_load(0);
    chk("t4_done",     64'(bus.done),     64'd1);
    chk("t4_hold",     64'(bus.cpu_hold), 64'd1);
    @(negedge clk);
    chk("t4_done_drop", 64'(bus.done),    64'd0);
    chk("t4_nwrites",  64'(wa_q.size()),  64'd0);

    // Start and abort together in IDLE: abort wins
    bus.abort = 1'b1;
    start_load(1);
    bus.abort = 1'b0;
    chk("t5_start_abort_idle", 64'(bus.cpu_hold), 64'd0);

    // Abort partway through a word, then a fresh one-word load
    d0 = done_cnt;
    start_load(4);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("t5_abort_idle", 64'(bus.cpu_hold), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_abort_nowrite", 64'(wa_q.size()),   64'd0);
    chk("t5_abort_nodone",  64'(done_cnt - d0), 64'd0);
    start_load(1);
    send_word(32'h44332211);
    wait_done("t5_done_seen", 10);
    @(negedge clk);
    chk("t5_nwrites", 64'(wa_q.size()), 64'd1);
    chk("t5_addr",    64'(wa_q[0]),     64'd0);
    chk("t5_data",    64'(wd_q[0]),     64'h44332211);
    wa_q.delete(); wd_q.delete();

    // Oversized count clamps to the full memory depth
    start_load(1025);
    for (int i = 0; i < 1024; i++) send_word(32'h5A000000 | 32'(i));
    chk("t6_last_addr_live", 64'(bus.wr_addr), 64'h3FF);
    @(negedge clk);
    chk("t6_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    chk("t6_idle",     64'(bus.cpu_hold),   64'd0);
    chk("t6_nwrites",  64'(wa_q.size()),    64'd1024);
    bad = 0;
    if (wa_q.size() == 1024) begin
      for (int i = 0; i < 1024; i++)
        if (wa_q[i] !== 10'(i) || wd_q[i] !== (32'h5A000000 | 32'(i))) bad++;
      chk("t6_last_addr", 64'(wa_q[1023]), 64'h3FF);
      chk("t6_last_data", 64'(wd_q[1023]), 64'h5A0003FF);
    end
    chk("t6_bad_entries", 64'(bad), 64'd0);
    wa_q.delete(); wd_q.delete();

    // Asynchronous reset in the middle of a word
    start_load(3);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t1_hold_before_rst", 64'(bus.cpu_hold), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t1_async_hold",  64'(bus.cpu_hold),       64'd0);
    chk("t1_async_ready", 64'(bus.byte_ready),     64'd0);
    chk("t1_async_addr",  64'(bus.wr_addr),        64'd0);
    chk("t1_async_instr", 64'(bus.instruction_in), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    repeat (8) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("t1_post_rst_nowrite", 64'(wa_q.size()),   64'd0);
    chk("t1_post_rst_idle",    64'(bus.byte_ready), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
